// File: rtl/FetchUnitTypes.sv
// rtl/FetchUnitTypes.sv - shared BTB sizes, entry/queue types and PC field helpers
package FetchUnitTypes;

    localparam int PC_WIDTH            = 32;
    localparam int INSN_ADDR_BIT_WIDTH = 2;
    localparam int FETCH_WIDTH         = 2;
    localparam int UPDATE_WIDTH        = 2;

    localparam int BTB_ENTRY_NUM    = 1024;
    localparam int BTB_TAG_WIDTH    = 8;
    localparam int BTB_QUEUE_DEPTH  = 4;
    localparam int BTB_INDEX_WIDTH  = $clog2(BTB_ENTRY_NUM);
    localparam int BTB_TARGET_WIDTH = PC_WIDTH - INSN_ADDR_BIT_WIDTH;

    typedef logic [PC_WIDTH-1:0]         PC_Path;
    typedef logic [BTB_INDEX_WIDTH-1:0]  BTB_IndexPath;
    typedef logic [BTB_TAG_WIDTH-1:0]    BTB_TagPath;
    typedef logic [BTB_TARGET_WIDTH-1:0] BTB_TargetPath;

    typedef struct packed {
        logic          valid;
        BTB_TagPath    tag;
        BTB_TargetPath target;
    } BTB_EntryPath;

    typedef struct packed {
        BTB_IndexPath  index;
        BTB_TagPath    tag;
        BTB_TargetPath target;
    } BtbQueueEntry;

    function automatic BTB_IndexPath ToBTB_Index(input PC_Path pc);
        return pc[BTB_INDEX_WIDTH+INSN_ADDR_BIT_WIDTH-1:INSN_ADDR_BIT_WIDTH];
    endfunction

    function automatic BTB_TagPath ToBTB_Tag(input PC_Path pc);
        return pc[BTB_INDEX_WIDTH+BTB_TAG_WIDTH+INSN_ADDR_BIT_WIDTH-1:BTB_INDEX_WIDTH+INSN_ADDR_BIT_WIDTH];
    endfunction

    function automatic BTB_TargetPath ToBTB_Target(input PC_Path pc);
        return pc[PC_WIDTH-1:INSN_ADDR_BIT_WIDTH];
    endfunction

    // Rebuilds a full instruction address from a stored (word-aligned) target.
    function automatic PC_Path ToRawAddr(input BTB_TargetPath target);
        return {target, {INSN_ADDR_BIT_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/btb_update_queue.sv
// rtl/btb_update_queue.sv - circular FIFO of deferred BTB writes, multi-push single-pop
module btb_update_queue
    import FetchUnitTypes::*;
#(
    parameter int DEPTH      = BTB_QUEUE_DEPTH,
    parameter int PUSH_WIDTH = UPDATE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PUSH_WIDTH-1:0] pushValid,
    input  BtbQueueEntry          pushData [PUSH_WIDTH],
    input  logic                  pop,
    output BtbQueueEntry          headData,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] PtrPath;
    typedef logic [CNT_W-1:0] CountPath;

    BtbQueueEntry          storage [DEPTH];
    PtrPath                headPtr;
    PtrPath                tailPtr;
    PtrPath                tailNext;
    PtrPath                slotPtr [PUSH_WIDTH];
    CountPath              count;
    CountPath              countNext;
    logic [PUSH_WIDTH-1:0] slotWe;

    // Pack valid pushes into consecutive slots in lane order; a push that finds no room is dropped.
    always_comb begin
        tailNext  = tailPtr;
        countNext = count;
        for (int p = 0; p < PUSH_WIDTH; p++) begin
            slotWe[p]  = 1'b0;
            slotPtr[p] = tailNext;
            if (pushValid[p] && (countNext != CountPath'(DEPTH))) begin
                slotWe[p] = 1'b1;
                tailNext  = tailNext + PtrPath'(1);
                countNext = countNext + CountPath'(1);
            end
        end
        if (pop && !empty) begin
            countNext = countNext - CountPath'(1);
        end
    end

    // Pointer and occupancy state; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            tailPtr <= tailNext;
            count   <= countNext;
            if (pop && !empty) begin
                headPtr <= headPtr + PtrPath'(1);
            end
        end
    end

    // Entry storage, written only for accepted pushes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < PUSH_WIDTH; p++) begin
                if (slotWe[p]) begin
                    storage[slotPtr[p]] <= pushData[p];
                end
            end
        end
    end

    assign headData = storage[headPtr];
    assign full     = (count == CountPath'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/multi_read_block_ram.sv
// rtl/multi_read_block_ram.sv - multi-read, single-write block RAM with registered read-first ports
module multi_read_block_ram #(
    parameter int ENTRY_NUM      = 1024,
    parameter int ENTRY_BIT_SIZE = 8,
    parameter int READ_NUM       = 2
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(ENTRY_NUM)-1:0] wa,
    input  logic [ENTRY_BIT_SIZE-1:0]    wv,
    input  logic                         re,
    input  logic [$clog2(ENTRY_NUM)-1:0] ra [READ_NUM],
    output logic [ENTRY_BIT_SIZE-1:0]    rv [READ_NUM]
);

    logic [ENTRY_BIT_SIZE-1:0] array [ENTRY_NUM];

    // Single write port; no reset, contents are initialised by the owner.
    always_ff @(posedge clk) begin
        if (we) begin
            array[wa] <= wv;
        end
    end

    // Registered reads see the pre-write contents of a same-cycle write.
    always_ff @(posedge clk) begin
        if (re) begin
            for (int i = 0; i < READ_NUM; i++) begin
                rv[i] <= array[ra[i]];
            end
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped tagged BTB between NextPC and Fetch
module branch_target_buffer
    import FetchUnitTypes::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic [PC_WIDTH-1:0]     pred_pc,
    output logic [FETCH_WIDTH-1:0]  btb_hit,
    output logic [PC_WIDTH-1:0]     btb_target [FETCH_WIDTH],
    input  logic [UPDATE_WIDTH-1:0] upd_valid,
    input  logic [PC_WIDTH-1:0]     upd_pc [UPDATE_WIDTH],
    input  logic [PC_WIDTH-1:0]     upd_target [UPDATE_WIDTH],
    input  logic [UPDATE_WIDTH-1:0] upd_taken,
    input  logic [UPDATE_WIDTH-1:0] upd_mispred,
    output logic                    queue_full
);

    localparam int ENTRY_BITS = $bits(BTB_EntryPath);

    BTB_IndexPath           initIdx;
    logic                   readValid;
    logic                   readEnable;
    BTB_IndexPath           readIdx   [FETCH_WIDTH];
    BTB_TagPath             readTag   [FETCH_WIDTH];
    logic [ENTRY_BITS-1:0]  readData  [FETCH_WIDTH];
    BTB_EntryPath           readEntry [FETCH_WIDTH];

    logic                    ramWe;
    BTB_IndexPath            ramWa;
    BTB_EntryPath            ramWv;

    logic [UPDATE_WIDTH-1:0] eligible;
    logic                    mispredSeen;
    logic                    directTaken;
    logic [UPDATE_WIDTH-1:0] pushValid;
    BtbQueueEntry            pushData [UPDATE_WIDTH];
    BtbQueueEntry            headEntry;
    logic                    popEnable;
    logic                    queueEmpty;
    logic                    queueFullRaw;
    logic                    unusedBits;

    // Walks every entry during reset so the RAM needs no reset of its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            initIdx <= initIdx + BTB_IndexPath'(1);
        end else begin
            initIdx <= '0;
        end
    end

    // Per-lane read index: consecutive instructions from pred_pc, pinned to lane number in reset.
    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            readIdx[i] = rst ? BTB_IndexPath'(i) : ToBTB_Index(pred_pc + PC_Path'(4 * i));
        end
    end

    assign readEnable = rst || !stall;

    // Tags and result-valid flag travel alongside the RAM read so the Fetch-stage compare lines up.
    always_ff @(posedge clk) begin
        if (rst) begin
            readValid <= 1'b0;
        end else if (!stall) begin
            readValid <= 1'b1;
        end
        if (readEnable) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                readTag[i] <= ToBTB_Tag(pred_pc + PC_Path'(4 * i));
            end
        end
    end

    // Fetch-stage hit and target; a miss drives a zero target.
    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            readEntry[i]  = BTB_EntryPath'(readData[i]);
            btb_hit[i]    = !rst && readValid && readEntry[i].valid && (readEntry[i].tag == readTag[i]);
            btb_target[i] = btb_hit[i] ? ToRawAddr(readEntry[i].target) : '0;
        end
    end

    // A taken result only trains the BTB if no older lane in the same cycle mispredicted.
    always_comb begin
        eligible    = '0;
        mispredSeen = 1'b0;
        for (int j = 0; j < UPDATE_WIDTH; j++) begin
            eligible[j] = upd_valid[j] && upd_taken[j] && !mispredSeen;
            mispredSeen = mispredSeen || (upd_valid[j] && upd_mispred[j]);
        end
    end

    // Queue payload for every lane; only the push-enabled ones are stored.
    always_comb begin
        for (int j = 0; j < UPDATE_WIDTH; j++) begin
            pushData[j] = '{index:  ToBTB_Index(upd_pc[j]),
                            tag:    ToBTB_Tag(upd_pc[j]),
                            target: ToBTB_Target(upd_target[j])};
        end
    end

    // Arbitrate the single RAM write port: reset sweep, then lowest eligible lane, then queue drain.
    always_comb begin
        ramWe       = 1'b0;
        ramWa       = '0;
        ramWv       = '0;
        popEnable   = 1'b0;
        pushValid   = '0;
        directTaken = 1'b0;
        if (rst) begin
            ramWe = 1'b1;
            ramWa = initIdx;
        end else begin
            for (int j = 0; j < UPDATE_WIDTH; j++) begin
                if (eligible[j]) begin
                    if (!directTaken) begin
                        directTaken = 1'b1;
                        ramWe       = 1'b1;
                        ramWa       = pushData[j].index;
                        ramWv       = '{valid: 1'b1, tag: pushData[j].tag, target: pushData[j].target};
                    end else begin
                        pushValid[j] = 1'b1;
                    end
                end
            end
            if (!directTaken && !queueEmpty) begin
                popEnable = 1'b1;
                ramWe     = 1'b1;
                ramWa     = headEntry.index;
                ramWv     = '{valid: 1'b1, tag: headEntry.tag, target: headEntry.target};
            end
        end
    end

    // Address bits outside index/tag/target fields are intentionally ignored.
    always_comb begin
        unusedBits = 1'b0;
        for (int j = 0; j < UPDATE_WIDTH; j++) begin
            unusedBits = unusedBits ^ (^upd_pc[j]) ^ (^upd_target[j]);
        end
    end

    assign queue_full = queueFullRaw && !rst;

    multi_read_block_ram #(
        .ENTRY_NUM      (BTB_ENTRY_NUM),
        .ENTRY_BIT_SIZE (ENTRY_BITS),
        .READ_NUM       (FETCH_WIDTH)
    ) btbRam (
        .clk (clk),
        .we  (ramWe),
        .wa  (ramWa),
        .wv  (ramWv),
        .re  (readEnable),
        .ra  (readIdx),
        .rv  (readData)
    );

    btb_update_queue #(
        .DEPTH      (BTB_QUEUE_DEPTH),
        .PUSH_WIDTH (UPDATE_WIDTH)
    ) updateQueue (
        .clk       (clk),
        .rst       (rst),
        .pushValid (pushValid),
        .pushData  (pushData),
        .pop       (popEnable),
        .headData  (headEntry),
        .full      (queueFullRaw),
        .empty     (queueEmpty)
    );

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - self-checking bench for branch_target_buffer
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] pred_pc;
    logic [1:0]  btb_hit;
    logic [31:0] btb_target [2];
    logic [1:0]  upd_valid;
    logic [31:0] upd_pc [2];
    logic [31:0] upd_target [2];
    logic [1:0]  upd_taken;
    logic [1:0]  upd_mispred;
    logic        queue_full;

    always #5 clk = ~clk;

    branch_target_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .pred_pc     (pred_pc),
        .btb_hit     (btb_hit),
        .btb_target  (btb_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .upd_mispred (upd_mispred),
        .queue_full  (queue_full)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: table of trained branches plus a list of deferred updates.
    bit          mValid [1024];
    int unsigned mTag   [1024];
    logic [31:0] mTgt   [1024];
    typedef struct {
        int unsigned idx;
        int unsigned tag;
        logic [31:0] tgt;
    } upd_t;
    upd_t        mQueue [$];
    logic [1:0]  eHit;
    logic [31:0] eTgt [2];

    typedef struct {
        logic        st;
        logic [31:0] pred;
        logic [1:0]  uv, ut, um;
        logic [31:0] p0, t0, p1, t1;
        logic [1:0]  eh;
        logic [31:0] e0, e1;
        logic        ef;
    } vec_t;
    vec_t vecs [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic upd_t mkUpd(input logic [31:0] pc, input logic [31:0] tgt);
        upd_t u;
        u.idx = (pc / 4) % 1024;
        u.tag = (pc / 4096) % 256;
        u.tgt = tgt & 32'hFFFF_FFFC;
        return u;
    endfunction

    task automatic mWrite(input upd_t u);
        mValid[u.idx] = 1'b1;
        mTag[u.idx]   = u.tag;
        mTgt[u.idx]   = u.tgt;
    endtask

    task automatic modelEdge();
        logic [31:0] a;
        upd_t        u;
        bit          wrote;
        bit          blocked;
        if (rst) begin
            mQueue.delete();
            eHit    = 2'b00;
            eTgt[0] = '0;
            eTgt[1] = '0;
            return;
        end
        if (!stall) begin
            for (int i = 0; i < 2; i++) begin
                a = pred_pc + 32'(4 * i);
                u = mkUpd(a, 32'h0);
                eHit[i] = mValid[u.idx] && (mTag[u.idx] == u.tag);
                eTgt[i] = eHit[i] ? mTgt[u.idx] : 32'h0;
            end
        end
        wrote   = 1'b0;
        blocked = 1'b0;
        for (int j = 0; j < 2; j++) begin
            if (!blocked && upd_valid[j] && upd_taken[j]) begin
                u = mkUpd(upd_pc[j], upd_target[j]);
                if (!wrote) begin
                    mWrite(u);
                    wrote = 1'b1;
                end else if (mQueue.size() < 4) begin
                    mQueue.push_back(u);
                end
            end
            if (upd_valid[j] && upd_mispred[j]) blocked = 1'b1;
        end
        if (!wrote && mQueue.size() > 0) mWrite(mQueue.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic checkModel(input string pfx);
        chk({pfx, "_hit0"}, 32'(btb_hit[0]), 32'(eHit[0]));
        chk({pfx, "_hit1"}, 32'(btb_hit[1]), 32'(eHit[1]));
        chk({pfx, "_tgt0"}, btb_target[0], eTgt[0]);
        chk({pfx, "_tgt1"}, btb_target[1], eTgt[1]);
        chk({pfx, "_full"}, 32'(queue_full), 32'(mQueue.size() == 4));
    endtask

    function automatic logic [31:0] randPc();
        return ($urandom() & 32'hFFF0_0000) | (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    task automatic randomInputs(input bit allowStall);
        stall   = allowStall && ($urandom_range(0, 9) == 0);
        pred_pc = randPc();
        for (int j = 0; j < 2; j++) begin
            upd_valid[j]   = 1'($urandom_range(0, 1));
            upd_taken[j]   = ($urandom_range(0, 3) != 0);
            upd_mispred[j] = ($urandom_range(0, 3) == 0);
            upd_pc[j]      = randPc();
            upd_target[j]  = $urandom();
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        for (int c = 0; c < 1030; c++) begin
            randomInputs(1'b0);
            step();
            if (c == 0 || c == 511 || c == 1029) begin
                chk("rst_hit", 32'(btb_hit), 32'h0);
                chk("rst_tgt0", btb_target[0], 32'h0);
                chk("rst_tgt1", btb_target[1], 32'h0);
                chk("rst_full", 32'(queue_full), 32'h0);
            end
        end
        rst       = 1'b0;
        stall     = 1'b0;
        upd_valid = 2'b00;
        for (int i = 0; i < 1024; i++) mValid[i] = 1'b0;
    endtask

    task automatic addVec(input logic st, input logic [31:0] pred,
                          input logic [1:0] uv, input logic [1:0] ut, input logic [1:0] um,
                          input logic [31:0] p0, input logic [31:0] t0,
                          input logic [31:0] p1, input logic [31:0] t1,
                          input logic [1:0] eh, input logic [31:0] e0, input logic [31:0] e1,
                          input logic ef);
        vec_t v;
        v.st = st; v.pred = pred; v.uv = uv; v.ut = ut; v.um = um;
        v.p0 = p0; v.t0 = t0; v.p1 = p1; v.t1 = t1;
        v.eh = eh; v.e0 = e0; v.e1 = e1; v.ef = ef;
        vecs.push_back(v);
    endtask

    task automatic addIdle(input logic st, input logic [31:0] pred, input logic [1:0] eh,
                           input logic [31:0] e0, input logic [31:0] e1, input logic ef);
        addVec(st, pred, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, eh, e0, e1, ef);
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        pred_pc     = '0;
        upd_valid   = '0;
        upd_taken   = '0;
        upd_mispred = '0;
        upd_pc[0] = '0; upd_pc[1] = '0;
        upd_target[0] = '0; upd_target[1] = '0;
        for (int i = 0; i < 1024; i++) begin
            mValid[i] = 1'b0; mTag[i] = 0; mTgt[i] = '0;
        end
        eHit = 2'b00; eTgt[0] = '0; eTgt[1] = '0;

        // Directed rows: expected outputs observed after the row's clock edge.
        addIdle(0, 32'h1000, 2'b00, 0, 0, 0);
        addVec (0, 32'h1000, 2'b01, 2'b01, 2'b00, 32'h1000, 32'h2000, 0, 0, 2'b00, 0, 0, 0);
        addIdle(0, 32'h0000, 2'b00, 0, 0, 0);
        addIdle(0, 32'h1000, 2'b01, 32'h2000, 0, 0);
        addIdle(0, 32'h2000, 2'b00, 0, 0, 0);
        addVec (0, 32'h0, 2'b11, 2'b10, 2'b01, 32'h1100, 32'h0, 32'h3000, 32'h3800, 2'b00, 0, 0, 0);
        addIdle(0, 32'h3000, 2'b00, 0, 0, 0);
        addVec (0, 32'h0, 2'b11, 2'b11, 2'b00, 32'h4000, 32'h5000, 32'h4004, 32'h6000, 2'b00, 0, 0, 0);
        addIdle(0, 32'h0000, 2'b00, 0, 0, 0);
        addIdle(0, 32'h4000, 2'b11, 32'h5000, 32'h6000, 0);
        for (int k = 0; k < 5; k++)
            addVec(0, 32'h0, 2'b11, 2'b11, 2'b00, 32'hA00 + 32'(16 * k), 32'h7000 + 32'(256 * k),
                   32'hA04 + 32'(16 * k), 32'h7800 + 32'(256 * k), 2'b00, 0, 0, (k >= 3));
        for (int k = 0; k < 4; k++) addIdle(0, 32'h0, 2'b00, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            addIdle(0, 32'hA00 + 32'(16 * k), (k < 4) ? 2'b11 : 2'b01, 32'h7000 + 32'(256 * k),
                    (k < 4) ? 32'h7800 + 32'(256 * k) : 32'h0, 0);
        addIdle(0, 32'hA10, 2'b11, 32'h7100, 32'h7900, 0);
        addIdle(1, 32'h1000, 2'b11, 32'h7100, 32'h7900, 0);
        addIdle(0, 32'h0000, 2'b00, 0, 0, 0);
        addVec (0, 32'h0, 2'b01, 2'b01, 2'b00, 32'h1000, 32'h9000, 0, 0, 2'b00, 0, 0, 0);
        addIdle(0, 32'h0000, 2'b00, 0, 0, 0);
        addIdle(0, 32'h0FFC, 2'b10, 0, 32'h9000, 0);
        addVec (0, 32'h0, 2'b10, 2'b10, 2'b00, 0, 0, 32'h5008, 32'hABC3, 2'b00, 0, 0, 0);
        addIdle(0, 32'h5004, 2'b10, 0, 32'hABC0, 0);

        doReset();

        for (int r = 0; r < vecs.size(); r++) begin
            stall          = vecs[r].st;
            pred_pc        = vecs[r].pred;
            upd_valid      = vecs[r].uv;
            upd_taken      = vecs[r].ut;
            upd_mispred    = vecs[r].um;
            upd_pc[0]      = vecs[r].p0;
            upd_target[0]  = vecs[r].t0;
            upd_pc[1]      = vecs[r].p1;
            upd_target[1]  = vecs[r].t1;
            step();
            chk($sformatf("vec%0d_hit", r), 32'(btb_hit), 32'(vecs[r].eh));
            chk($sformatf("vec%0d_tgt0", r), btb_target[0], vecs[r].e0);
            chk($sformatf("vec%0d_tgt1", r), btb_target[1], vecs[r].e1);
            chk($sformatf("vec%0d_full", r), 32'(queue_full), 32'(vecs[r].ef));
        end

        for (int c = 0; c < 2000; c++) begin
            randomInputs(1'b1);
            step();
            checkModel("rand");
        end

        // Reset in the middle of traffic, with updates still queued.
        for (int c = 0; c < 6; c++) begin
            upd_valid = 2'b11; upd_taken = 2'b11; upd_mispred = 2'b00;
            upd_pc[0] = randPc(); upd_pc[1] = randPc();
            step();
        end
        doReset();
        chk("midrst_full", 32'(queue_full), 32'h0);

        for (int c = 0; c < 600; c++) begin
            randomInputs(1'b1);
            step();
            checkModel("post");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
